// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback word and commits it to the general-purpose register file.
// Define REGFILE_BYPASS_EN to route a same-cycle write straight onto the decode read ports.
module wb_regfile #(
    parameter  int NUM_REGS = 32,
    parameter  int DATA_W   = 32,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Regfile_weW,
    input  logic [1:0]        regSrc_muxW,
    input  logic [DATA_W-1:0] aluOutW,
    input  logic [DATA_W-1:0] readDataW,
    input  logic [DATA_W-1:0] pcPlus8W,
    input  logic [AW-1:0]     writeRegAddrW,
    input  logic [AW-1:0]     readAddr1D,
    input  logic [AW-1:0]     readAddr2D,
    output logic [DATA_W-1:0] readData1D,
    output logic [DATA_W-1:0] readData2D,
    output logic [DATA_W-1:0] wbDataW,
    output logic              wbWeW,
    output logic [AW-1:0]     wbAddrW
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] w_wb_data;
    logic              w_wb_we;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    // Writeback source mux; the reserved encoding falls back to the ALU result.
    always_comb begin
        w_wb_data = aluOutW;
        case (regSrc_muxW)
            2'b00:   w_wb_data = aluOutW;
            2'b01:   w_wb_data = readDataW;
            2'b10:   w_wb_data = pcPlus8W;
            default: w_wb_data = aluOutW;
        endcase
    end

    // Register 0 is hardwired, so a write aimed at it is never qualified.
    assign w_wb_we = Regfile_weW && (writeRegAddrW != {AW{1'b0}});

    // Register array: synchronous clear wins over any write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= {DATA_W{1'b0}};
            end
        end else if (w_wb_we) begin
            r_regs[writeRegAddrW] <= w_wb_data;
        end else begin
            r_regs[writeRegAddrW] <= r_regs[writeRegAddrW];
        end
    end

    // Decode read port 1; address 0 reads as zero on every path.
    always_comb begin
        w_rd1 = {DATA_W{1'b0}};
        if (readAddr1D == {AW{1'b0}}) begin
            w_rd1 = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
        end else if (w_wb_we && (readAddr1D == writeRegAddrW)) begin
            w_rd1 = w_wb_data;
`endif
        end else begin
            w_rd1 = r_regs[readAddr1D];
        end
    end

    // Decode read port 2, identical in structure to port 1.
    always_comb begin
        w_rd2 = {DATA_W{1'b0}};
        if (readAddr2D == {AW{1'b0}}) begin
            w_rd2 = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
        end else if (w_wb_we && (readAddr2D == writeRegAddrW)) begin
            w_rd2 = w_wb_data;
`endif
        end else begin
            w_rd2 = r_regs[readAddr2D];
        end
    end

    assign readData1D = w_rd1;
    assign readData2D = w_rd2;
    assign wbDataW    = w_wb_data;
    assign wbWeW      = w_wb_we;
    assign wbAddrW    = writeRegAddrW;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expected outputs, a negedge monitor compares them.
module tb_wb_regfile;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int K_RD1 = 0;
    localparam int K_RD2 = 1;
    localparam int K_WBD = 2;
    localparam int K_WE  = 3;
    localparam int K_WA  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        Regfile_weW;
    logic [1:0]  regSrc_muxW;
    logic [31:0] aluOutW;
    logic [31:0] readDataW;
    logic [31:0] pcPlus8W;
    logic [4:0]  writeRegAddrW;
    logic [4:0]  readAddr1D;
    logic [4:0]  readAddr2D;
    logic [31:0] readData1D;
    logic [31:0] readData2D;
    logic [31:0] wbDataW;
    logic        wbWeW;
    logic [4:0]  wbAddrW;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    wb_regfile dut (
        .clk           (clk),
        .rst           (rst),
        .Regfile_weW   (Regfile_weW),
        .regSrc_muxW   (regSrc_muxW),
        .aluOutW       (aluOutW),
        .readDataW     (readDataW),
        .pcPlus8W      (pcPlus8W),
        .writeRegAddrW (writeRegAddrW),
        .readAddr1D    (readAddr1D),
        .readAddr2D    (readAddr2D),
        .readData1D    (readData1D),
        .readData2D    (readData2D),
        .wbDataW       (wbDataW),
        .wbWeW         (wbWeW),
        .wbAddrW       (wbAddrW)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            K_RD1:   return readData1D;
            K_RD2:   return readData2D;
            K_WBD:   return wbDataW;
            K_WE:    return {31'd0, wbWeW};
            K_WA:    return {27'd0, wbAddrW};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: outputs settle mid-cycle, so everything queued this cycle is checked at negedge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] a;
            e = q.pop_front();
            a = actual(e.kind);
            n_checks++;
            if (a !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, a, e.exp);
            end
        end
    end

    task automatic expect_out(input int kind, input logic [31:0] v, input string nm);
        exp_t e;
        e.kind = kind;
        e.exp  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic drive(input logic r, input logic we, input logic [1:0] src,
                         input logic [31:0] alu, input logic [31:0] rdat, input logic [31:0] pc8,
                         input logic [4:0] wa, input logic [4:0] ra1, input logic [4:0] ra2);
        @(posedge clk);
        #1;
        rst           = r;
        Regfile_weW   = we;
        regSrc_muxW   = src;
        aluOutW       = alu;
        readDataW     = rdat;
        pcPlus8W      = pc8;
        writeRegAddrW = wa;
        readAddr1D    = ra1;
        readAddr2D    = ra2;
    endtask

    task automatic rd(input logic [4:0] ra1, input logic [4:0] ra2);
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, ra1, ra2);
    endtask

    initial begin
        logic [31:0] src_exp [3];
        logic [31:0] prev;
        src_exp[0] = 32'h11;
        src_exp[1] = 32'h22;
        src_exp[2] = 32'h33;

        rst = 1'b1; Regfile_weW = 1'b0; regSrc_muxW = 2'b00;
        aluOutW = 32'h0; readDataW = 32'h0; pcPlus8W = 32'h0;
        writeRegAddrW = 5'd0; readAddr1D = 5'd0; readAddr2D = 5'd0;

        // Reset state after the first edge.
        drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd31);
        expect_out(K_RD1, 32'h0, "reset_rd1_r5");
        expect_out(K_RD2, 32'h0, "reset_rd2_r31");

        // Write DEADBEEF to r5, then reset it away over two cycles.
        drive(1'b0, 1'b1, 2'b00, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd5, 5'd5, 5'd31);
        expect_out(K_WBD, 32'hDEAD_BEEF, "wb_data_r5");
        expect_out(K_WE,  32'h1, "wb_we_r5");
        expect_out(K_WA,  32'h5, "wb_addr_r5");
        expect_out(K_RD1, BYP ? 32'hDEAD_BEEF : 32'h0, "raw_r5");
        rd(5'd5, 5'd31);
        expect_out(K_RD1, 32'hDEAD_BEEF, "r5_written");
        drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd31);
        expect_out(K_RD1, 32'hDEAD_BEEF, "sync_reset_not_yet");
        drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd31);
        expect_out(K_RD1, 32'h0, "reset_clears_r5");
        rd(5'd5, 5'd31);
        expect_out(K_RD1, 32'h0, "post_reset_r5");
        expect_out(K_RD2, 32'h0, "post_reset_r31");

        // Source select 00/01/10 into r3, each read back on the next cycle.
        prev = 32'h0;
        for (int s = 0; s < 3; s++) begin
            drive(1'b0, 1'b1, s[1:0], 32'h11, 32'h22, 32'h33, 5'd3, 5'd3, 5'd0);
            expect_out(K_WBD, src_exp[s], "src_wb_data");
            expect_out(K_RD1, BYP ? src_exp[s] : prev, "src_same_cycle");
            expect_out(K_RD2, 32'h0, "r0_port2");
            rd(5'd3, 5'd3);
            expect_out(K_RD1, src_exp[s], "src_readback1");
            expect_out(K_RD2, src_exp[s], "src_readback2");
            prev = src_exp[s];
        end
        // Reserved select falls back to the ALU result; no write, so r3 keeps 0x33.
        drive(1'b0, 1'b0, 2'b11, 32'h44, 32'h22, 32'h33, 5'd3, 5'd3, 5'd0);
        expect_out(K_WBD, 32'h44, "src_reserved");
        expect_out(K_WE,  32'h0, "we_low");

        // r0 protection, including the bypass path.
        drive(1'b0, 1'b1, 2'b00, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        expect_out(K_WE,  32'h0, "r0_we");
        expect_out(K_RD1, 32'h0, "r0_same_cycle");
        rd(5'd0, 5'd3);
        expect_out(K_RD1, 32'h0, "r0_next");
        expect_out(K_RD2, 32'h33, "r3_kept");

        // Same-cycle read-after-write on r7.
        drive(1'b0, 1'b1, 2'b00, 32'h1, 32'h0, 32'h0, 5'd7, 5'd0, 5'd0);
        drive(1'b0, 1'b1, 2'b00, 32'hABCD, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7);
        expect_out(K_RD1, BYP ? 32'hABCD : 32'h1, "raw_r7_p1");
        expect_out(K_RD2, BYP ? 32'hABCD : 32'h1, "raw_r7_p2");
        rd(5'd7, 5'd0);
        expect_out(K_RD1, 32'hABCD, "raw_r7_next");

        // Disabled write, and an unknown select with the write off.
        drive(1'b0, 1'b0, 2'b00, 32'h55, 32'h0, 32'h0, 5'd9, 5'd9, 5'd0);
        expect_out(K_WE,  32'h0, "dis_we");
        expect_out(K_RD1, 32'h0, "dis_same");
        drive(1'b0, 1'b0, 2'bxx, 32'h66, 32'h0, 32'h0, 5'd3, 5'd9, 5'd3);
        expect_out(K_RD1, 32'h0, "dis_r9");
        rd(5'd9, 5'd3);
        expect_out(K_RD1, 32'h0, "dis_r9_after");
        expect_out(K_RD2, 32'h33, "x_src_r3_kept");

        // Reset priority over a simultaneous write to r4.
        drive(1'b1, 1'b1, 2'b00, 32'h77, 32'h0, 32'h0, 5'd4, 5'd4, 5'd3);
        expect_out(K_WE,  32'h1, "rst_we_follows");
        expect_out(K_WBD, 32'h77, "rst_wb_data");
        expect_out(K_RD1, BYP ? 32'h77 : 32'h0, "rst_raw_r4");
        rd(5'd4, 5'd3);
        expect_out(K_RD1, 32'h0, "rst_prio_r4");
        expect_out(K_RD2, 32'h0, "rst_cleared_r3");
        drive(1'b0, 1'b1, 2'b01, 32'h0, 32'h99, 32'h0, 5'd4, 5'd0, 5'd0);
        rd(5'd4, 5'd7);
        expect_out(K_RD1, 32'h99, "write_after_rst");
        expect_out(K_RD2, 32'h0, "r7_cleared");

        begin
            int budget;
            budget = 0;
            while (q.size() > 0 && budget < 20) begin
                @(posedge clk);
                budget++;
            end
            if (q.size() > 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL drain: %0d entries left, expected 0", q.size());
            end
        end
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-stage consumer of the MEM/WB pipeline outputs.
- Selects the writeback value, then commits it to the 32x32 general-purpose register file.
- Provides the two combinational decode-stage read ports.
- Exports the selected writeback word and its address/enable so the forwarding unit can bypass into EX.

Parameters:
- NUM_REGS, 32, number of architectural registers; address width is log2(NUM_REGS).
- DATA_W, 32, register and datapath width.

Ports:
- clk  in  1  clock; all writes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- Regfile_weW  in  1  writeback enable from MEM/WB.
- regSrc_muxW  in  2  writeback source select from MEM/WB.
- aluOutW  in  32  ALU result from MEM/WB.
- readDataW  in  32  load data from MEM/WB.
- pcPlus8W  in  32  link address (JAL/JALR).
- writeRegAddrW  in  5  destination register.
- readAddr1D  in  5  decode read port 1 address (rs).
- readAddr2D  in  5  decode read port 2 address (rt).
- readData1D  out  32  read port 1 data, combinational.
- readData2D  out  32  read port 2 data, combinational.
- wbDataW  out  32  selected writeback value, combinational, for the forwarding unit.
- wbWeW  out  1  qualified write enable: Regfile_weW and writeRegAddrW != 0.
- wbAddrW  out  5  equals writeRegAddrW.

Behaviour:
- Source select (combinational):
  - 2'b00 -> aluOutW
  - 2'b01 -> readDataW
  - 2'b10 -> pcPlus8W
  - 2'b11 -> aluOutW (reserved, defined fallback)
- Write:
  - At posedge clk with rst=0 and wbWeW=1, regs[writeRegAddrW] <= wbDataW.
  - Write latency is 1 cycle: the value is visible through the array on the cycle after the edge.
- Register 0:
  - Never written.
  - Reads of address 0 always return 0, including through the bypass path.
  - wbWeW=0 when writeRegAddrW=0, regardless of Regfile_weW.
- Reset:
  - At posedge clk with rst=1, all NUM_REGS entries <= 0; any simultaneous write is discarded.
  - After reset, readData1D = readData2D = 0 for every address.
  - Combinational outputs follow their inputs during reset; wbWeW still reflects the inputs.
  - Reset asserted mid-stream discards the write presented in that cycle; the next write after reset deasserts proceeds normally.
- Reads:
  - Purely combinational from the array, or from the bypass path when it is compiled in.
  - Both ports are independent; the same address on both ports returns the same data.
- Simultaneous read/write of the same nonzero address in one cycle:
  - Without bypass: returns the old array value.
  - With bypass: see Optional Feature.
- Unknown/X on regSrc_muxW while wbWeW=0 must not corrupt the array.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - If wbWeW=1 and readAddrND == writeRegAddrW, readDataND = wbDataW in the same cycle (write-through).
  - The hazard unit then needs no WB->D stall.
- Undefined:
  - No internal bypass; same-cycle reads return the pre-write value.
  - The hazard unit must stall decode one extra cycle for a WB->D dependency.
- Both builds must pass the same test plan; only the same-cycle read-after-write expectation differs.

Test Plan:
- Reset: hold rst=1 two cycles after writing 0xDEADBEEF to r5 -> readData1D(r5)=0 and readData2D(r31)=0.
- Source select: we=1, addr=r3, src=00/01/10 with aluOutW=0x11, readDataW=0x22, pcPlus8W=0x33 over three cycles, each followed by a read -> r3 reads 0x11, 0x22, 0x33; wbDataW matches in each write cycle.
- r0 protection: we=1, addr=0, aluOutW=0xFFFFFFFF -> wbWeW=0; readData1D(r0)=0 next cycle.
- Same-cycle RAW: r7 holds 0x1; write 0xABCD to r7 while readAddr1D=7 ->
  - 0xABCD with REGFILE_BYPASS_EN.
  - 0x1 without it.
  - 0xABCD on the following cycle in both builds.
- Disabled write: we=0, addr=r9, aluOutW=0x55 -> r9 unchanged (0); wbWeW=0.
- Reset priority: rst=1 and we=1 to r4 with 0x77 in the same cycle -> r4=0 after the edge.
